// File: rtl/enemies_wave_if.sv
// Wave controller bundle: collision-side requests in,
// per-enemy control and wave status out.
interface enemies_wave_if #(
  parameter int N_ENEMIES = 4
) ();
  logic                 startOfFrame;
  logic                 pause;
  logic                 startGame;
  logic [N_ENEMIES-1:0] enemyHit;
  logic [N_ENEMIES-1:0] bulletNear;
  logic [N_ENEMIES-1:0] aliveMask;
  logic [N_ENEMIES-1:0] spawnPulse;
  logic [N_ENEMIES-1:0] dodgeGrant;
  logic [3:0]           waveNum;
  logic [2:0]           speedLevel;
  logic                 waveCleared;
  logic                 busy;

  modport master (
    output startOfFrame,
    output pause,
    output startGame,
    output enemyHit,
    output bulletNear,
    input  aliveMask,
    input  spawnPulse,
    input  dodgeGrant,
    input  waveNum,
    input  speedLevel,
    input  waveCleared,
    input  busy
  );

  modport slave (
    input  startOfFrame,
    input  pause,
    input  startGame,
    input  enemyHit,
    input  bulletNear,
    output aliveMask,
    output spawnPulse,
    output dodgeGrant,
    output waveNum,
    output speedLevel,
    output waveCleared,
    output busy
  );
endinterface

// File: rtl/enemies_wave_controller.sv
// Enemy wave sequencer: staggered spawns, alive tracking,
// wave clear delay and a round-robin dodge token.
module enemies_wave_controller #(
  parameter int N_ENEMIES      = 4,
  parameter int SPAWN_GAP      = 30,
  parameter int CLEAR_DELAY    = 120,
  parameter int DODGE_COOLDOWN = 50,
  parameter int MAX_WAVE       = 15
) (
  input  logic          clk,
  input  logic          resetN,
  enemies_wave_if.slave bus
);

  localparam int N  = N_ENEMIES;
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(SPAWN_GAP + 1);
  localparam int CW = $clog2(CLEAR_DELAY + 1);
  localparam int DW = $clog2(DODGE_COOLDOWN + 1);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [N-1:0]  ONE  = N'(1);
  localparam logic [3:0]    WMAX = 4'(MAX_WAVE);

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    ACTIVE,
    CLEAR_WAIT
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] spawn_idx, spawn_idx_d;
  logic [SW-1:0] spawn_tmr, spawn_tmr_d;
  logic [CW-1:0] clear_tmr, clear_tmr_d;
  logic [DW-1:0] cool, cool_d;
  logic [IW-1:0] rr_ptr, rr_ptr_d;
  logic [3:0]    wave, wave_d;
  logic [2:0]    speed;
  logic [N-1:0]  alive, alive_d;
  logic [N-1:0]  spawn_q, spawn_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          cleared_q, cleared_d;
  logic          busy_q;
  logic [N-1:0]  req;
  logic          tick;
  logic          fighting;
  logic          pick_ok;
  logic [IW-1:0] pick_idx;
  int            cand;

  assign tick = bus.startOfFrame & ~bus.pause;
  assign req  = bus.bulletNear & alive;

  // Walk downward so the last hit is the first
  // requester at or after rr_ptr.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state;
    spawn_idx_d = spawn_idx;
    spawn_tmr_d = spawn_tmr;
    clear_tmr_d = clear_tmr;
    cool_d      = cool;
    rr_ptr_d    = rr_ptr;
    wave_d      = wave;
    spawn_d     = '0;
    grant_d     = '0;
    cleared_d   = 1'b0;
    fighting    = (state == SPAWN) ||
                  (state == ACTIVE);

    if (tick && cool != '0) cool_d = cool - DW'(1);

    unique case (state)
      IDLE: begin
        if (bus.startGame) begin
          state_d     = SPAWN;
          wave_d      = 4'd1;
          spawn_idx_d = '0;
          spawn_tmr_d = '0;
        end
      end
      SPAWN: begin
        if (tick) begin
          if (spawn_tmr == '0) begin
            spawn_d     = ONE << spawn_idx;
            spawn_tmr_d = SW'(SPAWN_GAP - 1);
            if (spawn_idx == LAST) state_d = ACTIVE;
            else spawn_idx_d = spawn_idx + IW'(1);
          end else begin
            spawn_tmr_d = spawn_tmr - SW'(1);
          end
        end
      end
      ACTIVE: begin
      end
      CLEAR_WAIT: begin
        if (tick) begin
          if (clear_tmr <= CW'(1)) begin
            state_d     = SPAWN;
            spawn_idx_d = '0;
            spawn_tmr_d = '0;
            wave_d      = (wave < WMAX) ?
                          wave + 4'd1 : wave;
          end else begin
            clear_tmr_d = clear_tmr - CW'(1);
          end
        end
      end
      default: begin
      end
    endcase

    alive_d = (alive & ~bus.enemyHit) | spawn_d;

    if ((state == ACTIVE ||
         (state == SPAWN && spawn_idx != '0)) &&
        alive_d == '0) begin
      state_d     = CLEAR_WAIT;
      clear_tmr_d = CW'(CLEAR_DELAY);
      cleared_d   = 1'b1;
    end

    // The token frees up on the frame the cooldown expires.
    if (fighting && tick && pick_ok &&
        cool <= DW'(1)) begin
      grant_d  = ONE << pick_idx;
      rr_ptr_d = (pick_idx == LAST) ?
                 '0 : pick_idx + IW'(1);
      cool_d   = DW'(DODGE_COOLDOWN);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      spawn_idx <= '0;
      spawn_tmr <= '0;
      clear_tmr <= '0;
      cool      <= '0;
      rr_ptr    <= '0;
      wave      <= '0;
      speed     <= '0;
      alive     <= '0;
      spawn_q   <= '0;
      grant_q   <= '0;
      cleared_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_d;
      spawn_idx <= spawn_idx_d;
      spawn_tmr <= spawn_tmr_d;
      clear_tmr <= clear_tmr_d;
      cool      <= cool_d;
      rr_ptr    <= rr_ptr_d;
      wave      <= wave_d;
      speed     <= (wave_d > 4'd7) ?
                   3'd7 : wave_d[2:0];
      alive     <= alive_d;
      spawn_q   <= spawn_d;
      grant_q   <= grant_d;
      cleared_q <= cleared_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.aliveMask   = alive;
  assign bus.spawnPulse  = spawn_q;
  assign bus.dodgeGrant  = grant_q;
  assign bus.waveNum     = wave;
  assign bus.speedLevel  = speed;
  assign bus.waveCleared = cleared_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_enemies_wave_controller.sv
// Bench for enemies_wave_controller: scenario tasks against
// a frame-counting reference model of the wave rules.
module tb_enemies_wave_controller;

  localparam int N    = 4;
  localparam int GAP  = 30;
  localparam int CLR  = 120;
  localparam int CD   = 50;
  localparam int MAXW = 15;
  localparam int W    = 3 * N + 9;
  localparam int BIG  = 1 << 20;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  enemies_wave_if #(.N_ENEMIES(N)) bus ();

  enemies_wave_controller #(
    .N_ENEMIES     (N),
    .SPAWN_GAP     (GAP),
    .CLEAR_DELAY   (CLR),
    .DODGE_COOLDOWN(CD),
    .MAX_WAVE      (MAXW)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int nfr    = 0;
  int spawn2_fr = 0;

  // one frame pulse every 4 clocks, changed just after posedge
  initial begin
    bus.startOfFrame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.startOfFrame = (cyc % 4 == 0);
    end
  end

  always @(posedge clk)
    if (resetN && bus.startOfFrame && !bus.pause) nfr++;

  logic [W-1:0] obs;
  assign obs = {bus.aliveMask, bus.spawnPulse,
                bus.dodgeGrant, bus.waveNum,
                bus.speedLevel, bus.waveCleared,
                bus.busy};

  // reference model: phases plus frames elapsed
  int           m_phase, m_wave, m_spawned;
  int           m_fr, m_wait, m_since, m_rr;
  logic [N-1:0] m_alive;
  logic [W-1:0] m_exp;
  logic         t_tick, t_clr, t_found;
  logic [N-1:0] t_sp, t_gr, t_req, t_nxt;
  int           t_old, t_olds, t_j, t_spd;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_phase   = 0;
      m_wave    = 0;
      m_spawned = 0;
      m_fr      = 0;
      m_wait    = 0;
      m_since   = BIG;
      m_rr      = 0;
      m_alive   = '0;
      m_exp     = '0;
    end else begin
      t_tick = bus.startOfFrame && !bus.pause;
      t_sp   = '0;
      t_gr   = '0;
      t_clr  = 1'b0;
      t_old  = m_phase;
      t_olds = m_spawned;
      if (t_tick && m_since < BIG) m_since++;
      t_req = bus.bulletNear & m_alive;
      if (t_tick && (t_old == 1 || t_old == 2) &&
          m_since >= CD && t_req != '0) begin
        t_found = 1'b0;
        for (int k = 0; k < N; k++) begin
          t_j = (m_rr + k) % N;
          if (!t_found && t_req[t_j]) begin
            t_found   = 1'b1;
            t_gr[t_j] = 1'b1;
            m_rr      = (t_j + 1) % N;
          end
        end
        m_since = 0;
      end
      case (t_old)
        0: if (bus.startGame) begin
          m_phase   = 1;
          m_wave    = 1;
          m_spawned = 0;
          m_fr      = 0;
        end
        1: if (t_tick) begin
          m_fr++;
          if (m_fr == 1 + m_spawned * GAP) begin
            t_sp[m_spawned] = 1'b1;
            m_spawned++;
            if (m_spawned == N) m_phase = 2;
          end
        end
        3: if (t_tick) begin
          m_wait++;
          if (m_wait == CLR) begin
            m_phase   = 1;
            m_fr      = 0;
            m_spawned = 0;
            if (m_wave < MAXW) m_wave++;
          end
        end
        default: ;
      endcase
      t_nxt = (m_alive & ~bus.enemyHit) | t_sp;
      if ((t_old == 2 || (t_old == 1 && t_olds > 0)) &&
          t_nxt == '0) begin
        m_phase = 3;
        m_wait  = 0;
        t_clr   = 1'b1;
      end
      m_alive = t_nxt;
      t_spd   = (m_wave > 7) ? 7 : m_wave;
      m_exp   = {m_alive, t_sp, t_gr, 4'(m_wave),
                 3'(t_spd), t_clr, (m_phase != 0)};
    end
  end

  task automatic test_reset();
    resetN         = 1'b0;
    bus.pause      = 1'b0;
    bus.startGame  = 1'b0;
    bus.enemyHit   = '0;
    bus.bulletNear = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (obs !== '0)
      $display("FAIL reset_outputs got=%h want=0", obs);
    else n_pass++;
    resetN = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (obs !== '0 || m_exp !== '0)
      $display("FAIL idle_quiet got=%h want=0", obs);
    else n_pass++;
  endtask

  task automatic test_spawn();
    int fr[$];
    logic [N-1:0] pat[$];
    int base;
    while (bus.startOfFrame) @(negedge clk);
    base = nfr;
    bus.startGame = 1'b1;
    @(negedge clk);
    bus.startGame = 1'b0;
    n_chk++;
    if (bus.busy !== 1'b1 || bus.waveNum !== 4'd1)
      $display("FAIL start_wave busy=%b wave=%0d want 1/1",
               bus.busy, bus.waveNum);
    else n_pass++;
    for (int c = 0; c < 600 && pat.size() < N; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL spawn_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.spawnPulse != '0) begin
        fr.push_back(nfr - base);
        pat.push_back(bus.spawnPulse);
      end
      if (c == 200) bus.startGame = 1'b1;
      else bus.startGame = 1'b0;
    end
    n_chk++;
    if (pat.size() != N)
      $display("FAIL spawn_count got=%0d want=%0d",
               pat.size(), N);
    else n_pass++;
    for (int i = 0; i < pat.size(); i++) begin
      n_chk++;
      if (fr[i] != 1 + i * GAP || pat[i] !== N'(1 << i))
        $display("FAIL spawn_%0d frame=%0d pat=%b want %0d/%b",
                 i, fr[i], pat[i], 1 + i * GAP, N'(1 << i));
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (bus.aliveMask !== '1 || bus.waveNum !== 4'd1)
      $display("FAIL spawn_done alive=%b wave=%0d want 1111/1",
               bus.aliveMask, bus.waveNum);
    else n_pass++;
  endtask

  task automatic test_dodge();
    int fr[$];
    logic [N-1:0] pat[$];
    bus.bulletNear = '1;
    for (int c = 0; c < 4 * 4 * CD + 40 && pat.size() < N;
         c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL dodge_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.dodgeGrant != '0) begin
        fr.push_back(nfr);
        pat.push_back(bus.dodgeGrant);
      end
    end
    n_chk++;
    if (pat.size() != N)
      $display("FAIL dodge_count got=%0d want=%0d",
               pat.size(), N);
    else n_pass++;
    for (int i = 0; i < pat.size(); i++) begin
      n_chk++;
      if (fr[i] - fr[0] != i * CD || pat[i] !== N'(1 << i))
        $display("FAIL dodge_%0d gap=%0d pat=%b want %0d/%b",
                 i, fr[i] - fr[0], pat[i], i * CD, N'(1 << i));
      else n_pass++;
    end
    for (int c = 0; c < 4 * 170; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL dodge_rand t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      bus.bulletNear = N'($urandom_range(0, (1 << N) - 1));
    end
    bus.bulletNear = '0;
  endtask

  task automatic test_hits_clear();
    int slot [5];
    logic [N-1:0] want [5];
    int nclr, base, c;
    slot = '{0, 0, 1, 2, 3};
    want = '{4'b1110, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    nclr = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      bus.enemyHit          = '0;
      bus.enemyHit[slot[s]] = 1'b1;
      @(negedge clk);
      bus.enemyHit = '0;
      n_chk++;
      if (bus.aliveMask !== want[s] || obs !== m_exp)
        $display("FAIL hit_%0d alive=%b want=%b",
                 s, bus.aliveMask, want[s]);
      else n_pass++;
      if (bus.waveCleared) nclr++;
    end
    base = nfr;
    c    = 0;
    while (bus.spawnPulse == '0 && c < 4 * (CLR + 10)) begin
      @(negedge clk);
      c++;
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL clear_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.waveCleared) nclr++;
    end
    n_chk++;
    if (nclr != 1)
      $display("FAIL clear_pulses got=%0d want=1", nclr);
    else n_pass++;
    n_chk++;
    if (bus.spawnPulse !== N'(1) || nfr - base != CLR + 1 ||
        bus.waveNum !== 4'd2)
      $display("FAIL next_wave sp=%b fr=%0d wave=%0d want %b/%0d/2",
               bus.spawnPulse, nfr - base, bus.waveNum,
               N'(1), CLR + 1);
    else n_pass++;
  endtask

  task automatic test_spawn_hit_same();
    int c;
    logic seen;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 4 * (3 * GAP + 10)) begin
      @(negedge clk);
      c++;
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL same_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.spawnPulse[2]) begin
        seen         = 1'b1;
        spawn2_fr    = nfr;
        bus.enemyHit = '0;
        n_chk++;
        if (bus.aliveMask[2] !== 1'b1)
          $display("FAIL spawn_beats_hit alive=%b want bit2=1",
                   bus.aliveMask);
        else n_pass++;
      end else begin
        bus.enemyHit = bus.startOfFrame ? N'(4) : '0;
      end
    end
    bus.enemyHit = '0;
    n_chk++;
    if (!seen) $display("FAIL same_timeout got=0 want=1");
    else n_pass++;
  endtask

  task automatic test_pause();
    int nsp, ngr, c;
    nsp = 0;
    ngr = 0;
    repeat (40) @(negedge clk);
    bus.pause      = 1'b1;
    bus.bulletNear = '1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL pause_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.spawnPulse != '0) nsp++;
      if (bus.dodgeGrant != '0) ngr++;
      bus.enemyHit = (i == 200) ? N'(1) : '0;
    end
    n_chk++;
    if (nsp != 0 || ngr != 0)
      $display("FAIL pause_frozen spawns=%0d grants=%0d want 0/0",
               nsp, ngr);
    else n_pass++;
    n_chk++;
    if (bus.aliveMask !== 4'b0110)
      $display("FAIL pause_hit alive=%b want=0110",
               bus.aliveMask);
    else n_pass++;
    bus.pause      = 1'b0;
    bus.bulletNear = '0;
    c = 0;
    while (bus.spawnPulse == '0 && c < 4 * (GAP + 10)) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (bus.spawnPulse !== 4'b1000 || nfr - spawn2_fr != GAP)
      $display("FAIL pause_resume sp=%b gap=%0d want 1000/%0d",
               bus.spawnPulse, nfr - spawn2_fr, GAP);
    else n_pass++;
  endtask

  task automatic test_waves();
    int nclr, maxw, c;
    nclr = 0;
    maxw = 0;
    c    = 0;
    while (nclr < 20 && c < 15000) begin
      @(negedge clk);
      c++;
      n_chk++;
      if (obs !== m_exp)
        $display("FAIL waves_model t=%0t got=%h want=%h",
                 $time, obs, m_exp);
      else n_pass++;
      if (bus.waveCleared) nclr++;
      if (int'(bus.waveNum) > maxw) maxw = int'(bus.waveNum);
      bus.enemyHit  = N'($urandom_range(0, (1 << N) - 1));
      bus.startGame = (c % 97 == 5);
    end
    bus.enemyHit  = '0;
    bus.startGame = 1'b0;
    n_chk++;
    if (nclr != 20)
      $display("FAIL waves_count got=%0d want=20", nclr);
    else n_pass++;
    n_chk++;
    if (bus.waveNum !== 4'(MAXW) || bus.speedLevel !== 3'd7 ||
        maxw != MAXW)
      $display("FAIL waves_sat wave=%0d spd=%0d max=%0d want 15/7/15",
               bus.waveNum, bus.speedLevel, maxw);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c;
    c = 0;
    while (bus.spawnPulse == '0 && c < 4 * (CLR + 10)) begin
      @(negedge clk);
      c++;
    end
    n_chk++;
    if (bus.spawnPulse === '0)
      $display("FAIL mid_spawn_timeout got=0 want=spawn");
    else n_pass++;
    repeat (5) @(negedge clk);
    resetN = 1'b0;
    #1;
    n_chk++;
    if (obs !== '0)
      $display("FAIL async_reset got=%h want=0", obs);
    else n_pass++;
    @(negedge clk);
    resetN = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (obs !== '0 || m_exp !== '0)
      $display("FAIL post_reset_idle got=%h want=0", obs);
    else n_pass++;
    bus.startGame = 1'b1;
    @(negedge clk);
    bus.startGame = 1'b0;
    n_chk++;
    if (bus.waveNum !== 4'd1 || bus.busy !== 1'b1 ||
        obs !== m_exp)
      $display("FAIL restart got=%h want=%h", obs, m_exp);
    else n_pass++;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spawn();
    test_dodge();
    test_hits_clear();
    test_spawn_hit_same();
    test_pause();
    test_waves();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
